// File: rtl/cis_dvp_capture_if.sv
// Pixel stream handshake between the DVP capture block and the downstream ISP.
// Signal suffixes are named from the capture block's point of view.
interface cis_dvp_capture_if #(
   parameter int DW = 10
) ();
   logic          pix_valid_o;
   logic          pix_ready_i;
   logic [DW-1:0] pix_data_o;
   logic          pix_sof_o;
   logic          pix_eol_o;

   modport master (
      output pix_valid_o,
      output pix_data_o,
      output pix_sof_o,
      output pix_eol_o,
      input  pix_ready_i
   );

   modport slave (
      input  pix_valid_o,
      input  pix_data_o,
      input  pix_sof_o,
      input  pix_eol_o,
      output pix_ready_i
   );
endinterface

// File: rtl/cis_dvp_capture.sv
// Oversampling DVP camera capture: synchronizes the sensor bus, frames pixels
// into {sof, eol, data} words, buffers them in a show-ahead FIFO and generates XCLK.
module cis_dvp_capture #(
   parameter int DW         = 10,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic              cis_pclk_i,
   input  logic              cis_href_i,
   input  logic              cis_vsync_i,
   input  logic [DW-1:0]     cis_data_i,
   output logic              cis_xclk_o,
   input  logic              cap_en_i,
   input  logic [3:0]        xclk_div_i,
   input  logic              ovf_clr_i,
   output logic [15:0]       frame_cnt_o,
   output logic              ovf_o,
   output logic              frm_err_o,
   cis_dvp_capture_if.master pix_if
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int WW = DW + 2;
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_WAIT_SOF = 2'd1;
   localparam logic [1:0] ST_CAPTURE  = 2'd2;

   // [0],[1] form the synchronizer, [2] is the delayed copy for edge detection
   logic [2:0]    pclk_q, href_q, vsync_q;
   logic [DW-1:0] data_s1_q, data_s2_q;

   logic [1:0]    state_q, state_d;
   logic          hold_vld_q, hold_vld_d;
   logic [DW-1:0] hold_data_q, hold_data_d;
   logic          sof_pend_q, sof_pend_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   logic          ovf_q, frm_err_q;

   logic [WW-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]   wr_ptr_q, rd_ptr_q;

   logic [3:0]    xclk_cnt_q, xclk_div_q;
   logic          xclk_q;

   logic          pclk_rise, href_fall, vsync_rise, vsync_fall;
   logic          push_req, push_eol, frm_err_set;
   logic [DW-1:0] push_data;
   logic          fifo_empty, fifo_full, pop, push_ok, ovf_set;

   assign pclk_rise  = pclk_q[1] & ~pclk_q[2];
   assign href_fall  = ~href_q[1] & href_q[2];
   assign vsync_rise = vsync_q[1] & ~vsync_q[2];
   assign vsync_fall = ~vsync_q[1] & vsync_q[2];

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         pclk_q    <= '0;
         href_q    <= '0;
         vsync_q   <= '0;
         data_s1_q <= '0;
         data_s2_q <= '0;
      end else begin
         pclk_q    <= {pclk_q[1:0], cis_pclk_i};
         href_q    <= {href_q[1:0], cis_href_i};
         vsync_q   <= {vsync_q[1:0], cis_vsync_i};
         data_s1_q <= cis_data_i;
         data_s2_q <= data_s1_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      hold_vld_d  = hold_vld_q;
      hold_data_d = hold_data_q;
      sof_pend_d  = sof_pend_q;
      frame_cnt_d = frame_cnt_q;
      push_req    = 1'b0;
      push_eol    = 1'b0;
      push_data   = hold_data_q;
      frm_err_set = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cap_en_i) state_d = ST_WAIT_SOF;
         end
         ST_WAIT_SOF: begin
            if (!cap_en_i) begin
               state_d = ST_IDLE;
            end else if (vsync_fall) begin
               state_d    = ST_CAPTURE;
               sof_pend_d = 1'b1;
               hold_vld_d = 1'b0;
            end
         end
         ST_CAPTURE: begin
            // Frame end wins over any pixel landing in the same cycle
            if (vsync_rise) begin
               push_req    = hold_vld_q;
               push_eol    = 1'b1;
               hold_vld_d  = 1'b0;
               frame_cnt_d = frame_cnt_q + 16'd1;
               frm_err_set = href_q[1];
               state_d     = cap_en_i ? ST_WAIT_SOF : ST_IDLE;
            end else if (pclk_rise && href_q[1]) begin
               push_req    = hold_vld_q;
               hold_data_d = data_s2_q;
               hold_vld_d  = 1'b1;
            end else if (href_fall && hold_vld_q) begin
               push_req   = 1'b1;
               push_eol   = 1'b1;
               hold_vld_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (push_req) sof_pend_d = 1'b0;
   end

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop        = ~fifo_empty & pix_if.pix_ready_i;
   assign push_ok    = push_req & (~fifo_full | pop);
   assign ovf_set    = push_req & fifo_full & ~pop;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q     <= ST_IDLE;
         hold_vld_q  <= 1'b0;
         hold_data_q <= '0;
         sof_pend_q  <= 1'b0;
         frame_cnt_q <= '0;
         ovf_q       <= 1'b0;
         frm_err_q   <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         hold_vld_q  <= hold_vld_d;
         hold_data_q <= hold_data_d;
         sof_pend_q  <= sof_pend_d;
         frame_cnt_q <= frame_cnt_d;
         ovf_q       <= (ovf_q & ~ovf_clr_i) | ovf_set;
         frm_err_q   <= (frm_err_q & ~ovf_clr_i) | frm_err_set;
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   // Storage is not reset; the output mux masks it while the FIFO is empty
   always_ff @(posedge wb_clk_i) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {sof_pend_q, push_eol, push_data};
   end

   assign pix_if.pix_valid_o = ~fifo_empty;
   assign {pix_if.pix_sof_o, pix_if.pix_eol_o, pix_if.pix_data_o} =
      fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   // Divider value is latched at each toggle so a change applies from the next half-period
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         xclk_cnt_q <= '0;
         xclk_div_q <= '0;
         xclk_q     <= 1'b0;
      end else if (xclk_cnt_q >= xclk_div_q) begin
         xclk_cnt_q <= '0;
         xclk_div_q <= xclk_div_i;
         xclk_q     <= ~xclk_q;
      end else begin
         xclk_cnt_q <= xclk_cnt_q + 4'd1;
      end
   end

   assign cis_xclk_o  = xclk_q;
   assign frame_cnt_o = frame_cnt_q;
   assign ovf_o       = ovf_q;
   assign frm_err_o   = frm_err_q;

endmodule

// File: doc/cis_dvp_capture.md
CIS_DVP_CAPTURE -- requirements
Module: cis_dvp_capture

Interface
REQ-001 Parameter DW, default 10, CIS pixel data width (D9-D0).
REQ-002 Parameter FIFO_DEPTH, default 8, pixel FIFO entries; power of two, minimum 4.
REQ-003 wb_clk_i  in  1  sole clock; all inputs and outputs are sampled or driven on its rising edge.
REQ-004 wb_rst_ni  in  1  asynchronous, active-low reset.
REQ-005 cis_pclk_i  in  1  sensor PICLK, treated as data and oversampled; wb_clk_i frequency shall be at least 4x PICLK.
REQ-006 cis_href_i  in  1  sensor HSYNC/HREF; high marks valid pixels of a line.
REQ-007 cis_vsync_i  in  1  sensor VSYNC; a high pulse separates frames.
REQ-008 cis_data_i  in  DW  sensor pixel data, captured on the PICLK rising edge.
REQ-009 cis_xclk_o  out  1  sensor master clock generated from wb_clk_i.
REQ-010 cap_en_i  in  1  capture enable.
REQ-011 xclk_div_i  in  4  XCLK half-period, in wb_clk_i cycles, minus 1.
REQ-012 ovf_clr_i  in  1  one-cycle pulse that clears the ovf_o and frm_err_o sticky flags.
REQ-013 pix_valid_o / pix_ready_i  out / in  1 / 1  downstream ISP stream handshake.
REQ-014 pix_data_o  out  DW  pixel value.
REQ-015 pix_sof_o, pix_eol_o  out  1 each  flags for the first pixel of a frame and the last pixel of a line.
REQ-016 frame_cnt_o  out  16  number of completed frames; wraps from 0xFFFF to 0.
REQ-017 ovf_o, frm_err_o  out  1 each  sticky error flags.

Function
REQ-018 cis_pclk_i, cis_href_i, cis_vsync_i and cis_data_i shall each pass through a 2-flop synchronizer; a third PCLK flop shall drive the edge detector.
REQ-019 A PCLK rising edge is a cycle in which sync PCLK is 1 and its delayed copy is 0.
- Synchronized data and HREF shall be sampled in that same cycle.
REQ-020 VSYNC and HREF edges shall be detected on the synchronized signals using the same delayed-copy method.
REQ-021 FSM states:
- IDLE -> WAIT_SOF when cap_en_i=1.
- WAIT_SOF -> CAPTURE on a VSYNC falling edge.
- CAPTURE -> WAIT_SOF on a VSYNC rising edge, or -> IDLE instead if cap_en_i=0 at that edge.
REQ-022 cap_en_i=0 shall return the FSM to IDLE immediately from WAIT_SOF; in CAPTURE, deassertion shall take effect only at frame end.
REQ-023 In CAPTURE, each PCLK rising edge with HREF=1 shall load the pixel into a one-entry hold register.
- If the hold register was already full, its previous content shall be pushed to the FIFO with eol=0.
REQ-024 An HREF falling edge with the hold register full shall push the held pixel with eol=1 and empty the hold register.
REQ-025 The first push after entering CAPTURE shall carry sof=1; all other pushes carry sof=0.
REQ-026 The FIFO shall store {sof, eol, data} and use show-ahead output. pix_valid_o shall rise the cycle after a push into an empty FIFO.
REQ-027 A transfer occurs when pix_valid_o=1 and pix_ready_i=1.
- pix_data_o and the flags shall be held stable while pix_valid_o=1 and pix_ready_i=0.
REQ-028 A push into a full FIFO shall be discarded and set ovf_o. A simultaneous pop and push when full shall succeed without overflow.
REQ-029 A VSYNC rising edge in CAPTURE shall:
- push any held pixel with eol=1;
- increment frame_cnt_o;
- set frm_err_o if HREF was still high (truncated line).
REQ-030 ovf_clr_i shall clear both sticky flags. If a set event occurs in the same cycle, the set shall win.
REQ-031 cis_xclk_o shall toggle every xclk_div_i+1 cycles, running in all states. A new xclk_div_i value shall take effect at the next toggle.

Reset
REQ-032 While wb_rst_ni=0, the following shall be cleared asynchronously:
- FSM to IDLE;
- synchronizers, hold register, FIFO pointers and the divider counter;
- pix_valid_o, pix_sof_o, pix_eol_o, pix_data_o, cis_xclk_o, ovf_o and frm_err_o to 0;
- frame_cnt_o to 0.
REQ-033 Reset asserted mid-frame shall discard all buffered pixels. After release, capture shall resume only after a new VSYNC falling edge.

Verification
REQ-034 The bench shall drive cap_en=1, one 4x2 frame with data 0x001..0x008 and PCLK = wb_clk/4.
- Required: 8 transfers carrying 0x001..0x008.
- sof only on 0x001; eol on 0x004 and 0x008; frame_cnt_o=1; no flags set.
REQ-035 The bench shall send a 20-pixel line with pix_ready_i=0, then raise ready.
- Required: exactly 0x001..0x008 delivered, none with eol; ovf_o=1.
- ovf_clr_i pulse -> ovf_o=0.
REQ-036 The bench shall raise VSYNC while HREF=1 after 3 pixels.
- Required: 3 pixels delivered, the third with eol=1; frm_err_o=1; frame_cnt_o incremented.
REQ-037 The bench shall pulse wb_rst_ni low mid-line with 5 pixels buffered.
- Required: pix_valid_o=0 immediately.
- Pixels arriving before the next VSYNC falling edge shall be ignored.
REQ-038 The bench shall set xclk_div_i=2.
- Required: cis_xclk_o has period 6 wb_clk_i cycles.
- After a change to xclk_div_i=0, the period shall be 2 cycles from the next toggle onward.
